// File: rtl/cmp4_mult_pkg.sv
// Shared types and helpers for the pipelined cmp4 Dadda multiplier.
// approx_mult is the golden reference for approximate/exact products.
package cmp4_mult_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    function automatic int pw(input int width);
        return 2 * width;
    endfunction

    // Columns below k collapse to the OR of their bits; columns at or above k add exactly.
    function automatic logic [31:0] approx_mult(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'd0;
        lo = 32'd0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if ((a[j] & b[i]) == 1'b1) begin
                    if (i + j >= k) begin
                        hi = hi + (32'd1 << (i + j));
                    end else begin
                        lo[i+j] = 1'b1;
                    end
                end
            end
        end
        return hi | lo;
    endfunction

endpackage

// File: rtl/cmp4_reduce_tree.sv
// Combinational partial-product reduction to sum/carry rows using
// row-wise 4:2 compressors and full-adder CSAs, with an OR-only low region.
module cmp4_reduce_tree
    import cmp4_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx_en,
    output logic [2*WIDTH-1:0]   sum_row,
    output logic [2*WIDTH-1:0]   carry_row
);

    localparam int PW = pw(WIDTH);
    localparam logic [PW-1:0] LOW_MASK = (APPROX_COLS == 0) ? {PW{1'b0}}
                                         : ({PW{1'b1}} >> (PW - APPROX_COLS));

    function automatic logic [PW-1:0] maj(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Returns {carry, sum}; the inner carry feeds the second adder one column up.
    function automatic logic [2*PW-1:0] c42(input logic [PW-1:0] x1, input logic [PW-1:0] x2,
                                            input logic [PW-1:0] x3, input logic [PW-1:0] x4);
        logic [PW-1:0] s1;
        logic [PW-1:0] cin;
        s1  = x1 ^ x2 ^ x3;
        cin = maj(x1, x2, x3) << 1;
        return {maj(s1, x4, cin) << 1, s1 ^ x4 ^ cin};
    endfunction

    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        return {maj(x, y, z) << 1, x ^ y ^ z};
    endfunction

    logic [PW-1:0] rows_s [WIDTH];
    logic [PW-1:0] nxt_s  [WIDTH];
    logic [PW-1:0] pp_s;
    logic [PW-1:0] or_bits_s;
    int            n_s;
    int            m_s;
    int            idx_s;

    // Build masked partial-product rows, then compress level by level down to two rows.
    always_comb begin
        or_bits_s = {PW{1'b0}};
        pp_s      = {PW{1'b0}};
        n_s       = WIDTH;
        m_s       = 0;
        idx_s     = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pp_s = PW'(a & {WIDTH{b[i]}}) << i;
            if (approx_en) begin
                rows_s[i] = pp_s & ~LOW_MASK;
                or_bits_s = or_bits_s | (pp_s & LOW_MASK);
            end else begin
                rows_s[i] = pp_s;
            end
            nxt_s[i] = {PW{1'b0}};
        end
        for (int lvl = 0; lvl < WIDTH; lvl++) begin
            if (n_s > 2) begin
                m_s   = 0;
                idx_s = 0;
                for (int i = 0; i < WIDTH; i++) begin
                    nxt_s[i] = {PW{1'b0}};
                end
                for (int g = 0; g < WIDTH; g++) begin
                    if (idx_s + 4 <= n_s) begin
                        {nxt_s[m_s+1], nxt_s[m_s]} = c42(rows_s[idx_s], rows_s[idx_s+1],
                                                         rows_s[idx_s+2], rows_s[idx_s+3]);
                        idx_s = idx_s + 4;
                        m_s   = m_s + 2;
                    end else if (idx_s + 3 == n_s) begin
                        {nxt_s[m_s+1], nxt_s[m_s]} = csa(rows_s[idx_s], rows_s[idx_s+1],
                                                         rows_s[idx_s+2]);
                        idx_s = idx_s + 3;
                        m_s   = m_s + 2;
                    end else if (idx_s < n_s) begin
                        nxt_s[m_s] = rows_s[idx_s];
                        idx_s = idx_s + 1;
                        m_s   = m_s + 1;
                    end else begin
                        m_s = m_s;
                    end
                end
                rows_s = nxt_s;
                n_s    = m_s;
            end else begin
                n_s = n_s;
            end
        end
        // Low columns of both rows are zero here, so the OR bits merge without carries.
        sum_row   = rows_s[0] | or_bits_s;
        carry_row = rows_s[1];
    end

endmodule

// File: rtl/dadda_cmp4_mult_pipe.sv
// Two-stage valid/ready multiplier: stage 1 registers the reduced rows,
// stage 2 registers the carry-propagate sum.
module dadda_cmp4_mult_pipe
    import cmp4_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 out_approx
);

    localparam int PW = pw(WIDTH);

    logic          v1_r;
    logic          v2_r;
    logic [PW-1:0] s1_sum_r;
    logic [PW-1:0] s1_carry_r;
    logic          s1_approx_r;
    logic [PW-1:0] p_r;
    logic          approx_r;
    logic [PW-1:0] sum_s;
    logic [PW-1:0] carry_s;
    logic          adv2_s;
    logic          approx_en_s;

    assign approx_en_s = (in_approx == MODE_APPROX);
    assign adv2_s      = !v2_r || out_ready;
    assign in_ready    = !v1_r || adv2_s;
    assign out_valid   = v2_r;
    assign out_p       = p_r;
    assign out_approx  = approx_r;

    cmp4_reduce_tree #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_reduce (
        .a         (in_a),
        .b         (in_b),
        .approx_en (approx_en_s),
        .sum_row   (sum_s),
        .carry_row (carry_s)
    );

    // Stage 1: capture reduced rows whenever the stage is free or moving on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r        <= 1'b0;
            s1_sum_r    <= {PW{1'b0}};
            s1_carry_r  <= {PW{1'b0}};
            s1_approx_r <= 1'b0;
        end else if (in_ready) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_sum_r    <= sum_s;
                s1_carry_r  <= carry_s;
                s1_approx_r <= in_approx;
            end
        end
    end

    // Stage 2: final add, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r     <= 1'b0;
            p_r      <= {PW{1'b0}};
            approx_r <= 1'b0;
        end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                p_r      <= s1_sum_r + s1_carry_r;
                approx_r <= s1_approx_r;
            end
        end
    end

endmodule

// File: tb/tb_dadda_cmp4_mult_pipe.sv
// Scoreboard bench: acceptances push expected results, monitors pop on output transfers.
module tb_dadda_cmp4_mult_pipe;
    import cmp4_mult_pkg::*;

    typedef struct {
        logic [15:0] p;
        logic        m;
        int          c;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_approx, out_valid, out_ready, out_approx;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_p;

    logic        rst_n_sw;
    logic        w4_valid, w4_ready, w4_approx, w4_out_valid, w4_out_approx;
    logic [3:0]  w4_a, w4_b;
    logic [7:0]  w4_out_p;
    logic        w16_valid, w16_ready, w16_approx, w16_out_valid, w16_out_approx;
    logic [15:0] w16_a, w16_b;
    logic [31:0] w16_out_p;
    logic        sw_out_ready = 1'b1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    bit          lat_chk  = 1'b1;
    bit          done4    = 1'b0;
    bit          done16   = 1'b0;
    logic [15:0] cur_p;
    exp_t        q[$];
    logic [8:0]  q4[$];
    logic [32:0] q16[$];

    dadda_cmp4_mult_pipe #(.WIDTH(8), .APPROX_COLS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_approx(out_approx));

    dadda_cmp4_mult_pipe #(.WIDTH(4), .APPROX_COLS(0)) dut_w4 (
        .clk(clk), .rst_n(rst_n_sw), .in_valid(w4_valid), .in_ready(w4_ready),
        .in_a(w4_a), .in_b(w4_b), .in_approx(w4_approx), .out_valid(w4_out_valid),
        .out_ready(sw_out_ready), .out_p(w4_out_p), .out_approx(w4_out_approx));

    dadda_cmp4_mult_pipe #(.WIDTH(16), .APPROX_COLS(0)) dut_w16 (
        .clk(clk), .rst_n(rst_n_sw), .in_valid(w16_valid), .in_ready(w16_ready),
        .in_a(w16_a), .in_b(w16_b), .in_approx(w16_approx), .out_valid(w16_out_valid),
        .out_ready(sw_out_ready), .out_p(w16_out_p), .out_approx(w16_out_approx));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance side: record the expected result for each input transfer.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            q.push_back('{p: cur_p, m: in_approx, c: cyc, lat: lat_chk});
            n_acc++;
        end
        if (rst_n_sw && w4_valid && w4_ready)
            q4.push_back({w4_approx, 8'({4'd0, w4_a} * {4'd0, w4_b})});
        if (rst_n_sw && w16_valid && w16_ready)
            q16.push_back({w16_approx, 32'({16'd0, w16_a} * {16'd0, w16_b})});
    end

    // Output side: compare each result in order as it transfers.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("p", 32'(out_p), 32'(e.p));
                check("mode", 32'(out_approx), 32'(e.m));
                if (e.lat) check("latency", 32'(cyc - e.c), 32'd2);
            end
        end
        if (w4_out_valid) begin
            if (q4.size() == 0) check("w4_unexpected", 32'd1, 32'd0);
            else begin
                logic [8:0] e4;
                e4 = q4.pop_front();
                check("w4_p", 32'({w4_out_approx, w4_out_p}), 32'(e4));
            end
        end
        if (w16_out_valid) begin
            if (q16.size() == 0) check("w16_unexpected", 32'd1, 32'd0);
            else begin
                logic [32:0] e16;
                e16 = q16.pop_front();
                check("w16_p", w16_out_p, e16[31:0]);
                check("w16_mode", 32'(w16_out_approx), 32'(e16[32]));
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m, input logic [15:0] p);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_approx = m; cur_p = p;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Exhaustive WIDTH=4 sweep with APPROX_COLS=0 in both modes.
    initial begin
        w4_valid = 1'b0; w4_a = 4'd0; w4_b = 4'd0; w4_approx = 1'b0;
        @(posedge rst_n_sw);
        tick();
        for (int i = 0; i < 256; i++) begin
            w4_valid = 1'b1; w4_a = 4'(i >> 4); w4_b = 4'(i); w4_approx = 1'(i);
            @(negedge clk);
            if (!w4_ready) check("w4_ready", 32'd0, 32'd1);
            tick();
        end
        w4_valid = 1'b0;
        done4 = 1'b1;
    end

    // Directed WIDTH=16 vectors with APPROX_COLS=0.
    initial begin
        w16_valid = 1'b0; w16_a = 16'd0; w16_b = 16'd0; w16_approx = 1'b0;
        @(posedge rst_n_sw);
        tick();
        for (int i = 0; i < 18; i++) begin
            w16_valid  = 1'b1;
            w16_a      = (i == 17) ? 16'hFFFF : 16'(16'hFFFF - i * 16'h0F0F);
            w16_b      = (i == 17) ? 16'hFFFF : 16'(i * 16'h1357 + 1);
            w16_approx = 1'(i);
            @(negedge clk);
            if (!w16_ready) check("w16_ready", 32'd0, 32'd1);
            tick();
        end
        w16_valid = 1'b0;
        done16 = 1'b1;
    end

    logic [7:0]  bta [16] = '{8'h00, 8'h01, 8'hFF, 8'h0F, 8'hF0, 8'hAA, 8'h55, 8'h80,
                              8'h7F, 8'h33, 8'hCC, 8'h12, 8'hFE, 8'h9B, 8'h64, 8'h0C};
    logic [7:0]  btb [16] = '{8'hFF, 8'h01, 8'hFF, 8'hF0, 8'h0F, 8'h55, 8'h55, 8'h81,
                              8'h7F, 8'h3C, 8'h11, 8'h34, 8'h02, 8'hB9, 8'hC8, 8'h0D};
    logic [7:0]  bpa [5]  = '{8'd10, 8'd15, 8'd200, 8'd100, 8'd12};
    logic [7:0]  bpb [5]  = '{8'd20, 8'd15, 8'd2,   8'd100, 8'd12};
    logic [15:0] bpp [5]  = '{16'd200, 16'd225, 16'd400, 16'd10000, 16'd144};

    initial begin
        int          c0;
        int          idx;
        int          acc;
        logic [15:0] snap;
        logic [31:0] ref_p;
        rst_n = 1'b0; rst_n_sw = 1'b0;
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_approx = 1'b0; out_ready = 1'b1;
        cur_p = 16'd0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_out_approx", 32'(out_approx), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) tick();
        rst_n = 1'b1; rst_n_sw = 1'b1;

        send(8'd255, 8'd255, 1'b0, 16'd65025);
        send(8'd3,   8'd3,   1'b1, 16'd7);
        send(8'h80,  8'h80,  1'b1, 16'h4000);
        send(8'd255, 8'd255, 1'b1, 16'd64991);
        send(8'd7,   8'd7,   1'b1, 16'd31);
        send(8'd7,   8'd7,   1'b0, 16'd49);
        send(8'hFF,  8'h01,  1'b1, 16'h00FF);
        send(8'd0,   8'hFF,  1'b1, 16'd0);
        repeat (4) tick();

        c0 = cyc;
        for (int k = 0; k < 16; k++) begin
            ref_p = approx_mult({8'd0, bta[k]}, {8'd0, btb[k]}, k[0] ? 4 : 0);
            send(bta[k], btb[k], k[0], ref_p[15:0]);
        end
        check("b2b_cycles", 32'(cyc - c0), 32'd16);
        repeat (4) tick();

        lat_chk = 1'b0;
        out_ready = 1'b0;
        idx = 0; acc = 0; snap = 16'd0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_a = bpa[idx]; in_b = bpb[idx]; in_approx = 1'b0; cur_p = bpp[idx];
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (c == 2) snap = out_p;
            if (c > 2) check("bp_hold", 32'(out_p), 32'(snap));
            if (in_ready) begin
                acc++;
                idx++;
            end
            tick();
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_held_value", 32'(snap), 32'd200);
        out_ready = 1'b1;
        while (idx < 5) begin
            send(bpa[idx], bpb[idx], 1'b0, bpp[idx]);
            idx++;
        end
        repeat (5) tick();

        out_ready = 1'b0;
        send(8'd9, 8'd9, 1'b0, 16'd81);
        send(8'd5, 8'd5, 1'b1, 16'd25);
        #2;
        rst_n = 1'b0;
        n_acc = n_acc - q.size();
        q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_p", 32'(out_p), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1; out_ready = 1'b1; lat_chk = 1'b1;
        send(8'h0C, 8'h0D, 1'b0, 16'd156);
        repeat (5) tick();

        for (int t = 0; t < 2000 && !(done4 && done16); t++) @(negedge clk);
        repeat (5) tick();
        check("sweep_done", 32'({done4, done16}), 32'd3);
        check("queue_empty", 32'(q.size() + q4.size() + q16.size()), 32'd0);
        check("out_count", 32'(n_out), 32'(n_acc));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
